mm_control_param: RTL and testbench

Parametrised sequencer for the matrix-multiply datapath, computing P = A·x with A of size M×K, x of size K×N and P of size M×N, all row-major in separate memories. It is the generalised successor of the fixed 4×4 MM controller. It adds:
- compile-time dimensions
- a configurable datapath latency
- a stall input
- busy/done handshake outputs

It drives memory addresses, the accumulator load/accumulate select and the P write enable.

---
 rtl/mm_pkg.sv | 34 +++
 rtl/mm_delay_line.sv | 59 +++++
 rtl/mm_control_param.sv | 145 ++++++++++++++
 tb/tb_mm_control_param.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//   mm_state_t : sequencer states
//   clog2      : ceiling log2, usable in constant expressions
//   width_of   : bit width needed to hold 0..n-1, never less than 1
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mm_state_t;

  localparam int MM_MAX_DIM = 16;
  localparam int MM_MAX_LAT = 8;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // A product of 1 still needs a 1-bit address.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mm_delay_line.sv
// Enable-gated shift register carrying {valid, tag} pairs.
//   clk, rst  : clock, synchronous active-high reset (clears all stages)
//   en        : shift enable; low freezes every stage
//   in_valid  : entry valid bit
//   in_tag    : entry tag
//   out_valid : valid bit DEPTH enabled cycles later
//   out_tag   : tag DEPTH enabled cycles later
// DEPTH=0 is a plain wire.
module mm_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_tag   = in_tag;
    end else begin : g_pipe
      logic         valid_reg [DEPTH];
      logic [W-1:0] tag_reg   [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk) begin
            if (rst) begin
              valid_reg[gi] <= 1'b0;
              tag_reg[gi]   <= '0;
            end else if (en) begin
              valid_reg[gi] <= in_valid;
              tag_reg[gi]   <= in_tag;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            if (rst) begin
              valid_reg[gi] <= 1'b0;
              tag_reg[gi]   <= '0;
            end else if (en) begin
              valid_reg[gi] <= valid_reg[gi-1];
              tag_reg[gi]   <= tag_reg[gi-1];
            end
          end
        end
      end

      assign out_valid = valid_reg[DEPTH-1];
      assign out_tag   = tag_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mm_control_param.sv
// Sequencer for P = A * x (A: MxK, x: KxN, P: MxN, all row-major).
//   clk, rst  : clock, synchronous active-high reset
//   Start     : launch request, honoured only in IDLE
//   stall     : freezes state, counters, delay line and drain count
//   busy      : high in RUN and DRAIN
//   done      : one-cycle pulse after the final write
//   control   : 1 = accumulator load (k==0), 0 = accumulate
//   result_en : P write enable
//   addr_A    : i*K+k during RUN, else 0
//   addr_x    : k*N+j during RUN, else 0
//   addr_P    : i*N+j of the element being written, aligned with result_en
module mm_control_param
  import mm_pkg::*;
#(
  parameter int M       = 4,
  parameter int K       = 4,
  parameter int N       = 4,
  parameter int MAC_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Start,
  input  logic                         stall,
  output logic                         busy,
  output logic                         done,
  output logic                         control,
  output logic                         result_en,
  output logic [width_of(M*K)-1:0]     addr_A,
  output logic [width_of(K*N)-1:0]     addr_x,
  output logic [width_of(M*N)-1:0]     addr_P
);

  localparam int IW = width_of(M);
  localparam int JW = width_of(N);
  localparam int KW = width_of(K);
  localparam int DW = width_of(MAC_LAT);
  localparam int AW = width_of(M*K);
  localparam int XW = width_of(K*N);
  localparam int PW = width_of(M*N);

  mm_state_t     state_reg, state_next;
  logic [IW-1:0] i_reg, i_next;
  logic [JW-1:0] j_reg, j_next;
  logic [KW-1:0] k_reg, k_next;
  logic [DW-1:0] drain_reg, drain_next;

  logic          run;
  logic          k_last;
  logic [AW-1:0] a_calc;
  logic [XW-1:0] x_calc;
  logic [PW-1:0] tag_calc;
  logic          dl_valid;
  logic [PW-1:0] dl_tag;

  assign run      = (state_reg == ST_RUN);
  assign k_last   = (k_reg == KW'(K-1));
  assign a_calc   = AW'(int'(i_reg) * K + int'(k_reg));
  assign x_calc   = XW'(int'(k_reg) * N + int'(j_reg));
  assign tag_calc = PW'(int'(i_reg) * N + int'(j_reg));

  // State, counters and drain count all hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      drain_reg <= '0;
    end else if (!stall) begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      drain_reg <= drain_next;
    end
  end

  // Next state and loop counters: k innermost, then j, then i.
  // The counters wrap back to 0 on the last issue, ready for the next run.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    drain_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (Start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (k_last) begin
          k_next = '0;
          if (j_reg == JW'(N-1)) begin
            j_next = '0;
            if (i_reg == IW'(M-1)) begin
              i_next     = '0;
              state_next = (MAC_LAT > 0) ? ST_DRAIN : ST_DONE;
            end else begin
              i_next = i_reg + 1'b1;
            end
          end else begin
            j_next = j_reg + 1'b1;
          end
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DW'(MAC_LAT-1)) state_next = ST_DONE;
        else                             drain_next = drain_reg + 1'b1;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // An element's write becomes due once its k==K-1 term has been issued.
  mm_delay_line #(
    .DEPTH (MAC_LAT),
    .W     (PW)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .en        (!stall),
    .in_valid  (run && k_last),
    .in_tag    (run ? tag_calc : '0),
    .out_valid (dl_valid),
    .out_tag   (dl_tag)
  );

  always_comb begin
    busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    done      = (state_reg == ST_DONE) && !stall;
    control   = run && (k_reg == '0);
    addr_A    = run ? a_calc : '0;
    addr_x    = run ? x_calc : '0;
    result_en = dl_valid && !stall;
    addr_P    = dl_tag;
  end

endmodule

// File: tb/tb_mm_control_param.sv
module tb_mm_control_param;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic start1, start2;

  logic       busy1, done1, control1, re1;
  logic [3:0] aA1, ax1, aP1;
  logic       busy2, done2, control2, re2;
  logic [2:0] aA2;
  logic [3:0] ax2, aP2;

  always #5 clk = ~clk;

  mm_control_param u_dut1 (
    .clk(clk), .rst(rst), .Start(start1), .stall(stall),
    .busy(busy1), .done(done1), .control(control1), .result_en(re1),
    .addr_A(aA1), .addr_x(ax1), .addr_P(aP1)
  );

  mm_control_param #(.M(2), .K(3), .N(5), .MAC_LAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .Start(start2), .stall(stall),
    .busy(busy2), .done(done2), .control(control2), .result_en(re2),
    .addr_A(aA2), .addr_x(ax2), .addr_P(aP2)
  );

  typedef struct {
    int cyc;
    int addr;
  } wr_t;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } probe_t;

  wr_t    q1[$], q2[$];
  int     dq1[$], dq2[$];
  probe_t pq[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit end_req = 1'b0;
  bit end_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig(input int sel);
    case (sel)
      0: return int'(busy1);
      1: return int'(done1);
      2: return int'(control1);
      3: return int'(re1);
      4: return int'(aA1);
      5: return int'(ax1);
      6: return int'(aP1);
      7: return int'(aA2);
      8: return int'(ax2);
      default: return int'(busy2);
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0: return "busy1";
      1: return "done1";
      2: return "control1";
      3: return "result_en1";
      4: return "addr_A1";
      5: return "addr_x1";
      6: return "addr_P1";
      7: return "addr_A2";
      8: return "addr_x2";
      default: return "busy2";
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares, all against queued expectations.
  always @(negedge clk) begin
    probe_t p;
    wr_t    w;
    int     d;
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      if (p.cyc < cyc) cmp({sig_name(p.sel), "_probe_cycle"}, cyc, p.cyc);
      else             cmp(sig_name(p.sel), sig(p.sel), p.val);
    end
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      w = q1.pop_front();
      cmp("write1_missing", cyc, w.cyc);
    end
    while (q2.size() > 0 && q2[0].cyc < cyc) begin
      w = q2.pop_front();
      cmp("write2_missing", cyc, w.cyc);
    end
    while (dq1.size() > 0 && dq1[0] < cyc) begin
      d = dq1.pop_front();
      cmp("done1_missing", cyc, d);
    end
    while (dq2.size() > 0 && dq2[0] < cyc) begin
      d = dq2.pop_front();
      cmp("done2_missing", cyc, d);
    end
    if (re1) begin
      if (q1.size() == 0) cmp("write1_pending", 0, 1);
      else begin
        w = q1.pop_front();
        cmp("write1_cycle", cyc, w.cyc);
        cmp("write1_addr", int'(aP1), w.addr);
        $display("write1 cycle=%0d addr_P=%0d", cyc, aP1);
      end
    end
    if (re2) begin
      if (q2.size() == 0) cmp("write2_pending", 0, 1);
      else begin
        w = q2.pop_front();
        cmp("write2_cycle", cyc, w.cyc);
        cmp("write2_addr", int'(aP2), w.addr);
        $display("write2 cycle=%0d addr_P=%0d", cyc, aP2);
      end
    end
    if (done1) begin
      if (dq1.size() == 0) cmp("done1_pending", 0, 1);
      else begin
        d = dq1.pop_front();
        cmp("done1_cycle", cyc, d);
        $display("done1 cycle=%0d", cyc);
      end
    end
    if (done2) begin
      if (dq2.size() == 0) cmp("done2_pending", 0, 1);
      else begin
        d = dq2.pop_front();
        cmp("done2_cycle", cyc, d);
        $display("done2 cycle=%0d", cyc);
      end
    end
    if (end_req && !end_done) begin
      cmp("writes1_left", q1.size(), 0);
      cmp("writes2_left", q2.size(), 0);
      cmp("dones1_left", dq1.size(), 0);
      cmp("dones2_left", dq2.size(), 0);
      cmp("probes_left", pq.size(), 0);
      end_done = 1'b1;
    end
  end

  task automatic probe(input int c, input int sel, input int val);
    pq.push_back('{c, sel, val});
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic push_std_run(input int b);
    for (int e = 0; e < 16; e++) q1.push_back('{b + 4*e + 4, e});
    dq1.push_back(b + 65);
  endtask

  // Defaults, single Start pulse.
  task automatic run_basic();
    int b;
    b = cyc + 1;
    probe(cyc, 0, 0);
    probe(b, 0, 1);
    probe(b, 2, 1);
    probe(b + 1, 2, 0);
    probe(b + 1, 4, 1);
    probe(b + 1, 5, 4);
    probe(b + 4, 2, 1);
    probe(b + 8, 2, 1);
    probe(b + 65, 0, 0);
    probe(b + 66, 0, 0);
    push_std_run(b);
    pulse1();
    wait_cycle(b + 66);
  endtask

  initial begin
    int b;
    int t;
    int xs [6];
    xs = '{0, 5, 10, 1, 6, 11};
    rst = 1'b1;
    stall = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 10; s++) probe(cyc, s, 0);

    run_basic();

    // Stall for cycles 10..12: everything from cycle 10 slips by 3.
    b = cyc + 1;
    probe(b + 10, 4, 2);
    probe(b + 10, 5, 10);
    probe(b + 11, 4, 2);
    probe(b + 12, 4, 2);
    probe(b + 12, 5, 10);
    probe(b + 12, 3, 0);
    probe(b + 13, 4, 2);
    probe(b + 14, 4, 3);
    for (int e = 0; e < 16; e++) begin
      t = 4*e + 4;
      if (t >= 10) t = t + 3;
      q1.push_back('{b + t, e});
    end
    dq1.push_back(b + 68);
    pulse1();
    wait_cycle(b + 10);
    stall = 1'b1;
    wait_cycle(b + 13);
    stall = 1'b0;
    wait_cycle(b + 69);

    // One-cycle stall exactly on a write: the write is held then reappears.
    b = cyc + 1;
    probe(b + 16, 3, 0);
    probe(b + 16, 6, 3);
    probe(b + 17, 3, 1);
    probe(b + 17, 6, 3);
    for (int e = 0; e < 16; e++) begin
      t = 4*e + 4;
      if (t >= 16) t = t + 1;
      q1.push_back('{b + t, e});
    end
    dq1.push_back(b + 66);
    pulse1();
    wait_cycle(b + 16);
    stall = 1'b1;
    wait_cycle(b + 17);
    stall = 1'b0;
    wait_cycle(b + 67);

    // Start held high: three back-to-back runs, period 67.
    b = cyc + 1;
    probe(b + 66, 0, 0);
    probe(b + 67, 0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 16; e++) q1.push_back('{b + 67*r + 4*e + 4, e});
      dq1.push_back(b + 67*r + 65);
    end
    start1 = 1'b1;
    wait_cycle(b + 140);
    start1 = 1'b0;
    wait_cycle(b + 201);

    // Start pulse while busy is ignored.
    b = cyc + 1;
    probe(b + 20, 0, 1);
    probe(b + 66, 0, 0);
    probe(b + 67, 0, 0);
    probe(b + 68, 0, 0);
    push_std_run(b);
    pulse1();
    wait_cycle(b + 20);
    pulse1();
    wait_cycle(b + 68);

    // Reset at cycle 30: later writes and done are dropped.
    b = cyc + 1;
    for (int e = 0; e < 7; e++) q1.push_back('{b + 4*e + 4, e});
    for (int s = 0; s < 7; s++) probe(b + 31, s, 0);
    pulse1();
    wait_cycle(b + 30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycle(b + 33);
    run_basic();

    // 2x3x5 with zero latency.
    b = cyc + 1;
    for (int s = 0; s < 6; s++) begin
      probe(b + s, 7, s % 3);
      probe(b + s, 8, xs[s]);
    end
    probe(b + 15, 7, 3);
    probe(b + 15, 8, 0);
    probe(b + 29, 9, 1);
    probe(b + 30, 9, 0);
    for (int e = 0; e < 10; e++) q2.push_back('{b + 3*e + 2, e});
    dq2.push_back(b + 30);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    wait_cycle(b + 32);

    end_req = 1'b1;
    for (int n = 0; n < 10 && !end_done; n++) begin
      @(posedge clk);
      #1;
    end
    if (!end_done) $display("FAIL end_check actual=0 required=1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
